// File: rtl/gcu_types_pkg.sv
// Shared GCU types for the dependency scheduler and its queues.
// Contents: node/child-count widths, NodeTask_t descriptor, ROOT_ID,
// gcu_err_e error causes and the default scheduler ready-queue depth.
package gcu_types_pkg;

    localparam int NODE_ID_W        = 4;
    localparam int CHILD_CNT_W      = 4;
    localparam int FRONT_W          = 8;
    localparam int NUM_NODES        = 2 ** NODE_ID_W;
    localparam int SCHED_FIFO_DEPTH = 16;

    typedef logic [NODE_ID_W-1:0] node_id_t;

    // All-ones node ID names the virtual root; it is never a loadable node.
    localparam node_id_t ROOT_ID = '1;

    typedef struct packed {
        node_id_t                 node_id;
        node_id_t                 parent_id;
        logic [CHILD_CNT_W-1:0]   children_count;
        logic [FRONT_W-1:0]       front_size;
    } NodeTask_t;

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        LOAD_ROOT     = 3'd1,
        DUP_LOAD      = 3'd2,
        DONE_UNLOADED = 3'd3,
        DC_OVERFLOW   = 3'd4
    } gcu_err_e;

endpackage

// File: rtl/gcu_dep_scheduler_if.sv
// Handshake and status bundle of the dependency scheduler.
// load_*  : descriptor intake from the task loader
// done_*  : completion notifications from the compute engines
// issue_* : ready tasks towards the factorization datapath
// outstanding / root_done / err_* : status outputs
// master = loader/engine/datapath side, slave = scheduler.
interface gcu_dep_scheduler_if;
    import gcu_types_pkg::*;

    logic                load_valid;
    logic                load_ready;
    NodeTask_t           load_task;
    logic                done_valid;
    logic                done_ready;
    node_id_t            done_id;
    logic                issue_valid;
    logic                issue_ready;
    NodeTask_t           issue_task;
    logic [NODE_ID_W:0]  outstanding;
    logic                root_done;
    logic                err_valid;
    gcu_err_e            err_code;

    modport master (
        output load_valid, load_task, done_valid, done_id, issue_ready,
        input  load_ready, done_ready, issue_valid, issue_task,
               outstanding, root_done, err_valid, err_code
    );

    modport slave (
        input  load_valid, load_task, done_valid, done_id, issue_ready,
        output load_ready, done_ready, issue_valid, issue_task,
               outstanding, root_done, err_valid, err_code
    );

endinterface

// File: rtl/gcu_id_fifo.sv
// Synchronous FIFO of node IDs, reusable for GCU queues.
// Ports: clk, rst (sync, active-high), push/push_data, pop/pop_data (head,
// valid while !empty), full, empty, count. A push while full is accepted
// only together with a pop; a pop while empty is ignored.
module gcu_id_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty    = (cnt == '0);
    assign full     = (cnt == CW'(DEPTH));
    assign count    = cnt;
    assign pop_data = mem[rd_ptr];
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            if (do_push && !do_pop)      cnt <= cnt + CW'(1);
            else if (do_pop && !do_push) cnt <= cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/gcu_dep_scheduler.sv
// Dependency-tracking scheduler for the multifrontal elimination tree.
// Registers node descriptors, counts finished children per node and queues
// a node for issue once all of its children have completed.
// Ports: clk, rst (sync, active-high), sif (gcu_dep_scheduler_if.slave):
// load/done/issue handshakes plus outstanding, root_done and err status.
module gcu_dep_scheduler
    import gcu_types_pkg::*;
#(
    parameter int FIFO_DEPTH = SCHED_FIFO_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    gcu_dep_scheduler_if.slave sif
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OUT_W = NODE_ID_W + 1;

    logic [NUM_NODES-1:0]   vld_q;
    logic [CHILD_CNT_W-1:0] dc_q [NUM_NODES];
    NodeTask_t              task_q [NUM_NODES];
    logic [OUT_W-1:0]       outstanding_q;
    logic                   root_done_q;
    logic                   err_valid_q;
    gcu_err_e               err_code_q;

    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       fifo_count;
    node_id_t               push_id;
    node_id_t               head_id;

    logic                   load_acc;
    logic                   done_acc;
    logic                   load_ok;
    logic                   retire;
    logic                   dc_inc;
    logic                   root_nxt;
    gcu_err_e               err_nxt;
    node_id_t               ld_id;
    node_id_t               dn_id;
    node_id_t               par_id;
    logic [CHILD_CNT_W-1:0] par_dc_inc;

    // Done notifications win over loads, so at most one push per cycle.
    assign sif.done_ready  = !fifo_full;
    assign sif.load_ready  = !fifo_full && !sif.done_valid;
    assign sif.issue_valid = (fifo_count != '0);
    assign sif.issue_task  = fifo_empty ? '0 : task_q[head_id];
    assign sif.outstanding = outstanding_q;
    assign sif.root_done   = root_done_q;
    assign sif.err_valid   = err_valid_q;
    assign sif.err_code    = err_code_q;
    assign fifo_pop        = sif.issue_valid && sif.issue_ready;

    always_comb begin
        load_acc   = sif.load_valid && sif.load_ready;
        done_acc   = sif.done_valid && sif.done_ready;
        ld_id      = sif.load_task.node_id;
        dn_id      = sif.done_id;
        par_id     = task_q[dn_id].parent_id;
        par_dc_inc = dc_q[par_id] + CHILD_CNT_W'(1);
        load_ok    = 1'b0;
        retire     = 1'b0;
        dc_inc     = 1'b0;
        root_nxt   = 1'b0;
        err_nxt    = ERR_NONE;
        fifo_push  = 1'b0;
        push_id    = '0;
        if (load_acc) begin
            if (ld_id == ROOT_ID) begin
                err_nxt = LOAD_ROOT;
            end else if (vld_q[ld_id]) begin
                err_nxt = DUP_LOAD;
            end else begin
                load_ok = 1'b1;
                // Children may already have finished before the parent loaded.
                if (sif.load_task.children_count == dc_q[ld_id]) begin
                    fifo_push = 1'b1;
                    push_id   = ld_id;
                end
            end
        end else if (done_acc) begin
            if (!vld_q[dn_id]) begin
                err_nxt = DONE_UNLOADED;
            end else begin
                retire = 1'b1;
                if (par_id == ROOT_ID) begin
                    root_nxt = 1'b1;
                end else if (dc_q[par_id] == '1) begin
                    err_nxt = DC_OVERFLOW;
                end else begin
                    dc_inc = 1'b1;
                    if (vld_q[par_id] && (par_dc_inc == task_q[par_id].children_count)) begin
                        fifo_push = 1'b1;
                        push_id   = par_id;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q         <= '0;
            outstanding_q <= '0;
            root_done_q   <= 1'b0;
            err_valid_q   <= 1'b0;
            err_code_q    <= ERR_NONE;
            for (int i = 0; i < NUM_NODES; i++) begin
                dc_q[i]   <= '0;
                task_q[i] <= '0;
            end
        end else begin
            root_done_q <= root_nxt;
            err_valid_q <= (err_nxt != ERR_NONE);
            err_code_q  <= err_nxt;
            if (load_ok) begin
                vld_q[ld_id]  <= 1'b1;
                task_q[ld_id] <= sif.load_task;
                outstanding_q <= outstanding_q + OUT_W'(1);
            end
            if (retire) begin
                vld_q[dn_id]  <= 1'b0;
                dc_q[dn_id]   <= '0;
                task_q[dn_id] <= '0;
                outstanding_q <= outstanding_q - OUT_W'(1);
            end
            if (dc_inc) dc_q[par_id] <= par_dc_inc;
        end
    end

    gcu_id_fifo #(
        .WIDTH (NODE_ID_W),
        .DEPTH (FIFO_DEPTH)
    ) u_ready_q (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_id),
        .pop       (fifo_pop),
        .pop_data  (head_id),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_gcu_dep_scheduler.sv
// Scoreboard bench for gcu_dep_scheduler: directed stimulus pushes expected
// issues, errors and root completions; a negedge monitor pops and compares.
module tb_gcu_dep_scheduler;
    import gcu_types_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    gcu_dep_scheduler_if ifc();

    gcu_dep_scheduler #(.FIFO_DEPTH(SCHED_FIFO_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .sif (ifc)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;
    NodeTask_t exp_issue[$];
    gcu_err_e  exp_err[$];
    int exp_root = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic NodeTask_t mk(input int id, input int par, input int cc);
        NodeTask_t t;
        t.node_id        = NODE_ID_W'(id);
        t.parent_id      = NODE_ID_W'(par);
        t.children_count = CHILD_CNT_W'(cc);
        t.front_size     = FRONT_W'(id * 3 + 1);
        return t;
    endfunction

    // Called right after a posedge; returns #1 after the handshake edge.
    task automatic do_load(input NodeTask_t t);
        int n = 0;
        ifc.load_task  = t;
        ifc.load_valid = 1'b1;
        @(negedge clk);
        while (!ifc.load_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("load_handshake", ifc.load_ready, 1);
        @(posedge clk);
        #1;
        ifc.load_valid = 1'b0;
    endtask

    task automatic do_done(input int id);
        int n = 0;
        ifc.done_id    = NODE_ID_W'(id);
        ifc.done_valid = 1'b1;
        @(negedge clk);
        while (!ifc.done_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("done_handshake", ifc.done_ready, 1);
        @(posedge clk);
        #1;
        ifc.done_valid = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (ifc.issue_valid && ifc.issue_ready) begin
                    if (exp_issue.size() == 0) begin
                        total++;
                        $display("FAIL issue_unexpected: got node %0d expected none", ifc.issue_task.node_id);
                    end else begin
                        check("issue_task", longint'(ifc.issue_task), longint'(exp_issue.pop_front()));
                    end
                end
                if (ifc.err_valid) begin
                    if (exp_err.size() == 0) begin
                        total++;
                        $display("FAIL err_unexpected: got code %0d expected none", ifc.err_code);
                    end else begin
                        check("err_code", longint'(ifc.err_code), longint'(exp_err.pop_front()));
                    end
                end
                if (ifc.root_done) begin
                    total++;
                    if (exp_root > 0) begin
                        passed++;
                        exp_root--;
                    end else begin
                        $display("FAIL root_unexpected: got root_done=1 expected 0");
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        ifc.load_valid  = 1'b0;
        ifc.load_task   = '0;
        ifc.done_valid  = 1'b0;
        ifc.done_id     = '0;
        ifc.issue_ready = 1'b1;

        // Reset state
        step(1);
        check("rst_issue_valid", ifc.issue_valid, 0);
        check("rst_issue_task", longint'(ifc.issue_task), 0);
        check("rst_outstanding", ifc.outstanding, 0);
        check("rst_root_done", ifc.root_done, 0);
        check("rst_err_valid", ifc.err_valid, 0);
        step(1);
        rst = 1'b0;
        step(1);

        // Leaf issue
        exp_issue.push_back(mk(1, 15, 0));
        do_load(mk(1, 15, 0));
        check("leaf_issue_lat", ifc.issue_valid, 1);
        check("leaf_outstanding", ifc.outstanding, 1);
        step(1);
        exp_root++;
        do_done(1);
        check("leaf_root_done", ifc.root_done, 1);
        check("leaf_outstanding0", ifc.outstanding, 0);
        step(1);

        // Tree 1,2 -> 3 -> ROOT
        exp_issue.push_back(mk(1, 3, 0));
        do_load(mk(1, 3, 0));
        exp_issue.push_back(mk(2, 3, 0));
        do_load(mk(2, 3, 0));
        do_load(mk(3, 15, 2));
        check("tree_no_issue3", ifc.issue_valid, 0);
        check("tree_outstanding", ifc.outstanding, 3);
        do_done(1);
        check("tree_done1_nopush", ifc.issue_valid, 0);
        exp_issue.push_back(mk(3, 15, 2));
        do_done(2);
        check("tree_issue3", ifc.issue_valid, 1);
        step(1);
        exp_root++;
        do_done(3);
        check("tree_root_done", ifc.root_done, 1);
        check("tree_outstanding0", ifc.outstanding, 0);
        step(1);

        // Children finish before the parent is loaded
        exp_issue.push_back(mk(1, 3, 0));
        do_load(mk(1, 3, 0));
        exp_issue.push_back(mk(2, 3, 0));
        do_load(mk(2, 3, 0));
        step(1);
        do_done(1);
        do_done(2);
        check("early_no_issue", ifc.issue_valid, 0);
        exp_issue.push_back(mk(3, 15, 2));
        do_load(mk(3, 15, 2));
        check("early_issue3", ifc.issue_valid, 1);
        check("early_outstanding", ifc.outstanding, 1);
        step(1);
        exp_root++;
        do_done(3);
        check("early_root_done", ifc.root_done, 1);
        step(1);

        // Errors
        exp_issue.push_back(mk(1, 15, 0));
        do_load(mk(1, 15, 0));
        step(1);
        exp_err.push_back(DUP_LOAD);
        do_load(mk(1, 15, 0));
        check("dup_err_valid", ifc.err_valid, 1);
        check("dup_err_code", longint'(ifc.err_code), longint'(DUP_LOAD));
        check("dup_outstanding", ifc.outstanding, 1);
        step(1);
        check("dup_single_pulse", ifc.err_valid, 0);
        exp_err.push_back(DONE_UNLOADED);
        do_done(5);
        check("unl_err_code", longint'(ifc.err_code), longint'(DONE_UNLOADED));
        step(1);
        exp_err.push_back(LOAD_ROOT);
        do_load(mk(15, 15, 0));
        check("root_err_code", longint'(ifc.err_code), longint'(LOAD_ROOT));
        check("root_outstanding", ifc.outstanding, 1);
        step(1);
        exp_root++;
        do_done(1);
        check("err_outstanding0", ifc.outstanding, 0);
        step(1);

        // Back-pressure: 15 leaves queued, then drained in load order
        ifc.issue_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            exp_issue.push_back(mk(i, 15, 0));
            do_load(mk(i, 15, 0));
        end
        check("bp_outstanding", ifc.outstanding, 15);
        check("bp_issue_valid", ifc.issue_valid, 1);
        check("bp_head", ifc.issue_task.node_id, 0);
        ifc.issue_ready = 1'b1;
        n = 0;
        while (exp_issue.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_drained", exp_issue.size(), 0);
        step(1);
        for (int i = 0; i < 15; i++) begin
            exp_root++;
            do_done(i);
        end
        check("bp_outstanding0", ifc.outstanding, 0);
        step(1);

        // Done has priority over a load in the same cycle
        exp_issue.push_back(mk(6, 15, 0));
        do_load(mk(6, 15, 0));
        step(2);
        exp_root++;
        exp_issue.push_back(mk(4, 15, 0));
        ifc.load_task  = mk(4, 15, 0);
        ifc.load_valid = 1'b1;
        ifc.done_id    = NODE_ID_W'(6);
        ifc.done_valid = 1'b1;
        @(negedge clk);
        check("prio_load_ready", ifc.load_ready, 0);
        check("prio_done_ready", ifc.done_ready, 1);
        @(posedge clk);
        #1;
        ifc.done_valid = 1'b0;
        check("prio_root_done", ifc.root_done, 1);
        @(negedge clk);
        check("prio_load_ready1", ifc.load_ready, 1);
        @(posedge clk);
        #1;
        ifc.load_valid = 1'b0;
        check("prio_issue4", ifc.issue_valid, 1);
        check("prio_outstanding", ifc.outstanding, 1);
        step(1);
        exp_root++;
        do_done(4);
        step(1);

        // Reset mid-run with three queued tasks
        ifc.issue_ready = 1'b0;
        do_load(mk(7, 15, 0));
        do_load(mk(8, 15, 0));
        do_load(mk(9, 15, 0));
        check("mid_outstanding", ifc.outstanding, 3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_issue_valid", ifc.issue_valid, 0);
        check("mid_rst_outstanding", ifc.outstanding, 0);
        check("mid_rst_issue_task", longint'(ifc.issue_task), 0);
        ifc.issue_ready = 1'b1;
        exp_err.push_back(DONE_UNLOADED);
        do_done(7);
        check("mid_done_unloaded", longint'(ifc.err_code), longint'(DONE_UNLOADED));
        step(1);
        exp_issue.push_back(mk(7, 15, 0));
        do_load(mk(7, 15, 0));
        check("mid_reload", ifc.outstanding, 1);
        step(1);
        exp_root++;
        do_done(7);
        step(5);

        check("end_issue_q", exp_issue.size(), 0);
        check("end_err_q", exp_err.size(), 0);
        check("end_root_cnt", exp_root, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/gcu_dep_scheduler.md
Name: gcu_dep_scheduler

Overview:
- Dependency-tracking task scheduler for the GCU multifrontal elimination tree.
- Accepts NodeTask_t descriptors from the task loader.
- Counts completed children per node from compute-engine done notifications.
- Issues each node's descriptor to the factorization datapath once all its children have completed.

Parameters:
- NUM_NODES, 16 (2**NODE_ID_W): task table entries, indexed directly by node_id.
- FIFO_DEPTH, 16: ready-queue depth in node IDs. Must be >= NUM_NODES.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- load_valid  in  1  descriptor offered.
- load_ready  out  1  descriptor accepted when load_valid && load_ready.
- load_task  in  NodeTask_t  descriptor to register.
- done_valid  in  1  completion notification.
- done_ready  out  1  notification accepted when done_valid && done_ready.
- done_id  in  NODE_ID_W  node that finished.
- issue_valid  out  1  ready task available.
- issue_ready  in  1  datapath takes task when issue_valid && issue_ready.
- issue_task  out  NodeTask_t  descriptor of ready-queue head.
- outstanding  out  NODE_ID_W+1  nodes loaded but not yet retired.
- root_done  out  1  one-cycle pulse when a node whose parent_id == ROOT_ID retires.
- err_valid  out  1  one-cycle error pulse.
- err_code  out  gcu_err_e  error cause, valid with err_valid.

Behaviour:
- Per-entry state:
  - vld: descriptor loaded.
  - task: stored NodeTask_t.
  - dc: children done, CHILD_CNT_W bits.
- ROOT_ID = all-ones. Node ID NUM_NODES-1 is reserved and is never a loadable node.
- Reset:
  - Clears all vld and dc bits, empties the FIFO, and zeroes the outstanding counter.
  - All outputs are 0 in the cycle after rst is sampled high.
  - issue_task reads all-zero while issue_valid=0.
  - Mid-operation reset discards all in-flight state, with no partial pushes.
- Handshake readiness:
  - done_ready = !fifo_full.
  - load_ready = !fifo_full && !done_valid. A done notification takes priority; a load offered in the same cycle waits.
- At most one FIFO push per cycle.
- Load (accepted):
  - If node_id == ROOT_ID: err LOAD_ROOT, dropped.
  - Else if vld[node_id]: err DUP_LOAD, dropped, entry unchanged.
  - Otherwise set vld, store task, outstanding+1.
  - If children_count == dc[node_id] (covers leaves, and children that completed before the parent loaded): push node_id.
- Done (accepted):
  - If !vld[done_id]: err DONE_UNLOADED, ignored.
  - Otherwise retire done_id: clear vld and dc, outstanding-1, p = task.parent_id.
  - If p == ROOT_ID: pulse root_done.
  - Else if dc[p] == all-ones: err DC_OVERFLOW, dc[p] unchanged.
  - Else dc[p]+1. If vld[p] && dc[p]+1 == children_count[p], push p.
- Done and issue pop in the same cycle are both legal.
- Done and a load/done of the same entry: outputs are registered, so a load or done takes effect on the next cycle's table.
- FIFO:
  - Stores node IDs only. issue_task is read combinationally from table[head].task.
  - Latency: a push in cycle N gives issue_valid in N+1.
  - Push and pop in the same cycle are legal when full or empty+1; count stays unchanged.
- Retirement of a node still queued or unissued is the caller's error. It is not detected; issue_task then reads a cleared entry.
- err_valid and err_code are registered, reset to 0/ERR_NONE, and pulse for exactly one cycle per error.

Decomposition:
- gcu_types_pkg gains:
  - ROOT_ID constant ('1 of NODE_ID_W).
  - gcu_err_e enum: ERR_NONE, LOAD_ROOT, DUP_LOAD, DONE_UNLOADED, DC_OVERFLOW.
  - SCHED_FIFO_DEPTH default.
- One sub-module: gcu_id_fifo, a synchronous FIFO of NODE_ID_W entries with push/pop, full/empty and count. It is reusable for other GCU queues.

Test Plan:
- Leaf issue: load id1 (children 0, parent ROOT) -> issue_valid the cycle after the load handshake, issue_task.node_id=1, outstanding=1. Then done id1 -> root_done pulse, outstanding=0.
- Tree 1,2 -> 3 -> ROOT:
  - Load 1, 2 (cc=0) and 3 (cc=2) -> only 1 and 2 issue, in load order.
  - Done 1 -> no push.
  - Done 2 -> id3 issues the next cycle.
  - Done 3 -> root_done.
- Early children: load 1, 2 (parent 3); issue both; done 1 and 2 before 3 is loaded -> dc[3]=2. Then load 3 (cc=2) -> immediate push, issue_valid next cycle.
- Errors:
  - Load id1 twice -> DUP_LOAD, outstanding unchanged.
  - Done id5 (unloaded) -> DONE_UNLOADED.
  - Load id15 -> LOAD_ROOT.
  - Each error gives exactly one err_valid pulse.
- Back-pressure/priority:
  - Hold issue_ready=0 and fill 15 leaves -> all accepted, issue order preserved.
  - load_valid and done_valid asserted together -> load_ready=0 that cycle; the load completes the following cycle.
- Reset mid-run: with 3 queued tasks, assert rst one cycle -> issue_valid=0 and outstanding=0 next cycle; a subsequent done of an old id -> DONE_UNLOADED.
